// File: rtl/usb_fs_ep_pkg.sv
// Shared definitions for the full-speed USB endpoint buffers.
package usb_fs_ep_pkg;

  localparam int USB_MAX_PKT = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } ep_state_e;

endpackage

// File: rtl/usb_fs_ep_pkt_ram.sv
// Local packet store: one write port, one registered read port.
module usb_fs_ep_pkt_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Byte write from the capture stage.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Registered read; the address is always driven so the output can be prefetched.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/usb_fs_out_ep_buf.sv
// OUT endpoint consumer: pulls one packet from the protocol-engine buffer into a
// local RAM, then streams it to the application before asking for the next one.
//
// Stream handshake (rx_*): a byte moves on every rising clk edge where rx_valid and
// rx_ready are both 1. rx_valid never depends on rx_ready, and while rx_valid=1 and
// rx_ready=0, rx_data/rx_last/rx_setup/rx_len are held unchanged.
module usb_fs_out_ep_buf
  import usb_fs_ep_pkg::*;
#(
  parameter int MAX_PKT = USB_MAX_PKT,
  parameter int LEN_W   = $clog2(MAX_PKT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             out_ep_req,
  input  logic             out_ep_grant,
  input  logic             out_ep_data_avail,
  input  logic             out_ep_setup,
  output logic             out_ep_data_get,
  input  logic [7:0]       out_ep_data,
  output logic             out_ep_stall,
  input  logic             cfg_stall,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_last,
  output logic             rx_setup,
  output logic [LEN_W-1:0] rx_len,
  output logic             rx_zlp,
  output logic             rx_ovf,
  output logic [2:0]       dbg_state
);

  localparam int AW = $clog2(MAX_PKT);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  ep_state_e        state_q, state_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] rx_len_q, rx_len_d;
  logic             rx_setup_q, rx_setup_d;
  logic             rx_ovf_q, rx_ovf_d;
  logic             rx_zlp_q, rx_zlp_d;
  logic             cap_q, cap_d;
  logic             stall_q, stall_d;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;
  logic [7:0]       ram_rdata;

  usb_fs_ep_pkt_ram #(
    .DEPTH (MAX_PKT)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (out_ep_data),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  // State and datapath registers; reset drops any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_len_q   <= '0;
      rx_setup_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rx_zlp_q   <= 1'b0;
      cap_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_len_q   <= rx_len_d;
      rx_setup_q <= rx_setup_d;
      rx_ovf_q   <= rx_ovf_d;
      rx_zlp_q   <= rx_zlp_d;
      cap_q      <= cap_d;
      stall_q    <= stall_d;
    end
  end

  // Next-state, capture path and read-address prefetch.
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    rx_len_d        = rx_len_q;
    rx_setup_d      = rx_setup_q;
    rx_ovf_d        = rx_ovf_q;
    rx_zlp_d        = 1'b0;
    cap_d           = 1'b0;
    stall_d         = cfg_stall;
    out_ep_req      = 1'b0;
    out_ep_data_get = 1'b0;
    rx_valid        = 1'b0;
    rx_last         = 1'b0;
    ram_we          = 1'b0;
    ram_waddr       = wr_ptr_q[AW-1:0];

    // A get issued last cycle means out_ep_data holds a byte now; bytes past
    // MAX_PKT are dropped but still read so the PE buffer empties.
    if (cap_q) begin
      if (wr_ptr_q < MAX_LEN) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ONE;
      end else begin
        rx_ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (out_ep_data_avail) state_d = ST_REQ;
      end
      ST_REQ: begin
        out_ep_req      = 1'b1;
        out_ep_data_get = out_ep_grant & out_ep_data_avail;
        cap_d           = out_ep_data_get;
        if (out_ep_grant) begin
          state_d    = ST_READ;
          rx_setup_d = out_ep_setup;
          wr_ptr_d   = '0;
          rx_ovf_d   = 1'b0;
        end
      end
      ST_READ: begin
        out_ep_req      = 1'b1;
        out_ep_data_get = out_ep_grant & out_ep_data_avail;
        cap_d           = out_ep_data_get;
        if (!out_ep_data_avail && !cap_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        rx_len_d = wr_ptr_q;
        rd_ptr_d = '0;
        if (wr_ptr_q == '0) begin
          rx_zlp_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rx_valid = 1'b1;
        rx_last  = (rd_ptr_q == rx_len_q - ONE);
        if (rx_ready) begin
          if (rx_last) begin
            rd_ptr_d = '0;
            state_d  = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reading at the next pointer keeps one byte per cycle under continuous ready.
    ram_raddr = rd_ptr_d[AW-1:0];
  end

  assign rx_data      = rx_valid ? ram_rdata : 8'h00;
  assign rx_setup     = rx_setup_q;
  assign rx_len       = rx_len_q;
  assign rx_zlp       = rx_zlp_q;
  assign rx_ovf       = rx_ovf_q;
  assign out_ep_stall = stall_q;
  assign dbg_state    = state_q;

endmodule
